// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rmw
// Brief    : Load/store unit in front of a whole-word-write memory. Sub-word
//            stores are done as read-modify-write; loads return an aligned,
//            sign/zero-extended result. Optional feature macro
//            LSU_MISALIGN_EN splits misaligned halfword/word accesses across
//            two words; without it they complete with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw #(
  parameter int MEM_AW = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
`ifdef LSU_MISALIGN_EN
  localparam logic [2:0] S_RD1  = 3'd4;
  localparam logic [2:0] S_WR1  = 3'd5;
`endif
  localparam logic [4:0] C_RD_WORD = 5'b01111;
  localparam int         C_PADW    = 32 - MEM_AW;

  // Byte-enable pattern of an access size (funct3[1:0]) before shifting.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Replace the addressed bytes of a (possibly two-word) image with store data.
  function automatic logic [63:0] merge(input logic [63:0] orig,
                                        input logic [31:0] wd,
                                        input logic [1:0]  size,
                                        input logic [1:0]  off);
    logic [7:0]  bm;
    logic [63:0] data;
    logic [63:0] mask;
    bm   = {4'b0000, size_mask(size)} << off;
    data = {32'b0, wd} << {off, 3'b000};
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{bm[i]}};
    end
    merge = (orig & ~mask) | (data & mask);
  endfunction

  // Sign- or zero-extend a right-justified byte/halfword per funct3.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    extend = f3[2] ? {24'b0, v[7:0]}   : {{24{v[7]}}, v[7:0]};
      2'd1:    extend = f3[2] ? {16'b0, v[15:0]}  : {{16{v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  logic [2:0]        state_q;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [MEM_AW-1:0] word_q;
`ifdef LSU_MISALIGN_EN
  logic              mis_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;
`endif

  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic [3:0]        wmem_q;
  logic [4:0]        rmem_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       store_data_q;

  logic              w_legal;
  logic              w_aligned;
  logic [3:0]        w_lane;
  logic              w_signed;
  logic [MEM_AW-1:0] w_idx;
  logic [63:0]       w_orig;
  logic [63:0]       w_merge;
`ifdef LSU_MISALIGN_EN
  logic [63:0]       w_asm;
`endif

  // Classify the incoming request and build its byte-lane read code.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    if (req_store) begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = ~req_addr[0];
      default: w_aligned = (req_addr[1:0] == 2'b00);
    endcase
    w_lane   = size_mask(req_funct3[1:0]) << req_addr[1:0];
    // LW carries no sign bit: the word is already full width.
    w_signed = ~req_funct3[2] && (req_funct3[1:0] != 2'b10);
    w_idx    = req_addr[MEM_AW+1:2];
  end

  // Merge store data into the word(s) read back; RD1 merges across both words.
  always_comb begin
    w_orig = {32'b0, load_data};
`ifdef LSU_MISALIGN_EN
    if (state_q == S_RD1) begin
      w_orig = {load_data, lo_q};
    end
    w_asm = {load_data, lo_q} >> {off_q, 3'b000};
`endif
    w_merge = merge(w_orig, wdata_q, f3_q[1:0], off_q);
  end

  // Main sequencer: every memory-side and response output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 32'b0;
      word_q       <= '0;
`ifdef LSU_MISALIGN_EN
      mis_q        <= 1'b0;
      lo_q         <= 32'b0;
      hi_q         <= 32'b0;
`endif
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'b0;
      rsp_err_q    <= 1'b0;
      wmem_q       <= 4'b0000;
      rmem_q       <= 5'b00000;
      mem_addr_q   <= 32'b0;
      store_data_q <= 32'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            word_q  <= w_idx;
`ifdef LSU_MISALIGN_EN
            mis_q   <= ~w_aligned;
            if (!w_legal) begin
`else
            if (!w_legal || !w_aligned) begin
`endif
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'b0;
              state_q     <= S_RESP;
            end else begin
              // Stores and split accesses need the raw word; aligned loads
              // let the memory pick and extend the lanes.
              rmem_q     <= (req_store || !w_aligned) ? C_RD_WORD : {w_signed, w_lane};
              mem_addr_q <= {{C_PADW{1'b0}}, w_idx};
              state_q    <= S_RD0;
            end
          end
        end
        S_RD0: begin
`ifdef LSU_MISALIGN_EN
          lo_q <= load_data;
          if (mis_q) begin
            mem_addr_q <= {{C_PADW{1'b0}}, word_q + 1'b1};
            state_q    <= S_RD1;
          end else
`endif
          if (store_q) begin
            rmem_q       <= 5'b00000;
            wmem_q       <= 4'b1111;
            store_data_q <= w_merge[31:0];
            state_q      <= S_WR0;
          end else begin
            rmem_q      <= 5'b00000;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= load_data;
            state_q     <= S_RESP;
          end
        end
`ifdef LSU_MISALIGN_EN
        S_RD1: begin
          rmem_q <= 5'b00000;
          if (store_q) begin
            wmem_q       <= 4'b1111;
            store_data_q <= w_merge[31:0];
            hi_q         <= w_merge[63:32];
            mem_addr_q   <= {{C_PADW{1'b0}}, word_q};
            state_q      <= S_WR0;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= extend(w_asm[31:0], f3_q);
            state_q     <= S_RESP;
          end
        end
        S_WR1: begin
          wmem_q      <= 4'b0000;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= 32'b0;
          state_q     <= S_RESP;
        end
`endif
        S_WR0: begin
`ifdef LSU_MISALIGN_EN
          if (mis_q) begin
            store_data_q <= hi_q;
            mem_addr_q   <= {{C_PADW{1'b0}}, word_q + 1'b1};
            state_q      <= S_WR1;
          end else
`endif
          begin
            wmem_q      <= 4'b0000;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          rmem_q  <= 5'b00000;
          wmem_q  <= 4'b0000;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is a decode of the idle state, forced low while reset is held.
  assign req_ready  = (state_q == S_IDLE) && rst_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign wmem       = wmem_q;
  assign rmem       = rmem_q;
  assign mem_addr   = mem_addr_q;
  assign store_data = store_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_rmw
// Brief    : Directed bench for lsu_rmw with a small behavioural memory and a
//            response scoreboard. Misaligned cases follow LSU_MISALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  lsu_rmw #(.MEM_AW(30)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: 16 words aliased over the word index.
  logic [31:0] mem [0:15];
  logic [31:0] rdw;

  always_comb begin
    rdw = mem[mem_addr[3:0]];
    load_data = 32'b0;
    case (rmem[3:0])
      4'b1111: load_data = rdw;
      4'b0011: load_data = rmem[4] ? {{16{rdw[15]}}, rdw[15:0]}  : {16'b0, rdw[15:0]};
      4'b1100: load_data = rmem[4] ? {{16{rdw[31]}}, rdw[31:16]} : {16'b0, rdw[31:16]};
      4'b0001: load_data = rmem[4] ? {{24{rdw[7]}},  rdw[7:0]}   : {24'b0, rdw[7:0]};
      4'b0010: load_data = rmem[4] ? {{24{rdw[15]}}, rdw[15:8]}  : {24'b0, rdw[15:8]};
      4'b0100: load_data = rmem[4] ? {{24{rdw[23]}}, rdw[23:16]} : {24'b0, rdw[23:16]};
      4'b1000: load_data = rmem[4] ? {{24{rdw[31]}}, rdw[31:24]} : {24'b0, rdw[31:24]};
      default: load_data = 32'b0;
    endcase
  end

  always @(posedge clk) begin
    if (wmem == 4'b1111) mem[mem_addr[3:0]] <= store_data;
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Per-cycle observations after accept; index 1 = first cycle after accept.
  logic [4:0]  o_rmem [0:15];
  logic [3:0]  o_wmem [0:15];
  logic [31:0] o_sd   [0:15];
  logic [31:0] o_ma   [0:15];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, push its expected response, then collect the response.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input int lat);
    exp_t e;
    bit   got;
    e.data = ed; e.err = ee; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_ready"}, {63'b0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      o_rmem[i] = '0; o_wmem[i] = '0; o_sd[i] = '0; o_ma[i] = '0;
    end
    got = 1'b0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      o_rmem[k] = rmem; o_wmem[k] = wmem; o_sd[k] = store_data; o_ma[k] = mem_addr;
      if (k > 1) chk({tag, "_busy"}, {63'b0, req_ready}, 64'd0);
      if (rsp_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({tag, "_lat"},  k,                 e.lat);
        chk({tag, "_data"}, {32'b0, rsp_data}, {32'b0, e.data});
        chk({tag, "_err"},  {63'b0, rsp_err},  {63'b0, e.err});
      end
    end
    if (!got) begin
      void'(sb.pop_front());
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {63'b0, rsp_valid}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'b0; req_wdata = 32'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'b0, req_ready}, 64'd0);
    chk("rst_rsp",   {31'b0, rsp_valid, rsp_data}, 64'd0);
    chk("rst_mem",   {27'b0, rmem, wmem, store_data}, 64'd0);
    chk("rst_addr",  {32'b0, mem_addr}, 64'd0);
    rst_n = 1'b1;
    #1 chk("rel_ready", {63'b0, req_ready}, 64'd1);

    // Aligned loads
    mem[1] = 32'h8899AABB;
    do_req("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2);
    chk("lh6_rmem", {59'b0, o_rmem[1]}, {59'b0, 5'b11100});
    chk("lh6_addr", {32'b0, o_ma[1]}, 64'd1);
    do_req("lbu5", 1'b0, 3'b100, 32'h5, 32'h0, 32'h000000AA, 1'b0, 2);
    chk("lbu5_rmem", {59'b0, o_rmem[1]}, {59'b0, 5'b00010});
    do_req("lb5", 1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    do_req("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2);
    chk("lw4_rmem", {59'b0, o_rmem[1]}, {59'b0, 5'b01111});
    chk("lw4_hold", {32'b0, rsp_data}, {32'b0, 32'h8899AABB});

    // Aligned stores
    mem[2] = 32'h11223344;
    do_req("sb9", 1'b1, 3'b000, 32'h9, 32'h123456EE, 32'h0, 1'b0, 3);
    chk("sb9_rd",   {59'b0, o_rmem[1]}, {59'b0, 5'b01111});
    chk("sb9_wmem", {60'b0, o_wmem[2]}, {60'b0, 4'b1111});
    chk("sb9_sd",   {32'b0, o_sd[2]},   {32'b0, 32'h1122EE44});
    chk("sb9_mem",  {32'b0, mem[2]},    {32'b0, 32'h1122EE44});
    do_req("sha", 1'b1, 3'b001, 32'hA, 32'h0000BEEF, 32'h0, 1'b0, 3);
    chk("sha_mem", {32'b0, mem[2]}, {32'b0, 32'hBEEFEE44});
    do_req("sw8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    chk("sw8_mem", {32'b0, mem[2]}, {32'b0, 32'hDEADBEEF});

    // Illegal funct3
    do_req("ild3", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1);
    chk("ild3_mem", {55'b0, o_rmem[1], o_wmem[1]}, 64'd0);
    do_req("ist4", 1'b1, 3'b100, 32'h4, 32'h0, 32'h0, 1'b1, 1);
    chk("ist4_mem", {32'b0, mem[1]}, {32'b0, 32'h8899AABB});

`ifdef LSU_MISALIGN_EN
    // Split accesses
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h44332211;
    do_req("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 32'h2211DDCC, 1'b0, 3);
    chk("lw2_addr", {o_ma[1], o_ma[2]}, {32'd0, 32'd1});
    do_req("sw3", 1'b1, 3'b010, 32'h3, 32'hCAFEBABE, 32'h0, 1'b0, 5);
    chk("sw3_w0", {32'b0, mem[0]}, {32'b0, 32'hBECCBBAA});
    chk("sw3_w1", {32'b0, mem[1]}, {32'b0, 32'h44CAFEBA});
    do_req("lhwrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFAA00, 1'b0, 3);
    chk("lhwrap_addr", {o_ma[1], o_ma[2]}, {32'h3FFFFFFF, 32'd0});
`else
    // Misaligned without splitting
    do_req("lh1", 1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    chk("lh1_mem", {55'b0, o_rmem[1], o_wmem[1]}, 64'd0);
`endif

    // Reset landing in RD0 of a store
    mem[3] = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'hC; req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rrd0_rmem", {59'b0, rmem}, {59'b0, 5'b01111});
    rst_n = 1'b0;
    #1;
    chk("rrd0_clear", {55'b0, rmem, wmem}, 64'd0);
    chk("rrd0_ready", {63'b0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("rrd0_mem", {32'b0, mem[3]}, {32'b0, 32'h55667788});
    rst_n = 1'b1;
    #1 chk("rrd0_rel", {63'b0, req_ready}, 64'd1);
    do_req("lbud", 1'b0, 3'b100, 32'hD, 32'h0, 32'h00000077, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the directed sequence stalls outside a bounded wait.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
